sr_latch_ctrl: RTL and testbench

SR_LATCH_CTRL -- requirements
Module: sr_latch_ctrl

---
 rtl/sr_latch_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 36 +++
 rtl/sr_latch_ctrl.sv | 148 ++++++++++++++
 tb/tb_sr_latch_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sr_latch_pkg.sv
// sr_latch_pkg: shared definitions for the gated SR latch controller.
// Holds the FSM state encodings, the set/reset operation encodings and
// the default values of the controller parameters.
package sr_latch_pkg;

  localparam int unsigned N_REQ_DEFAULT    = 4;
  localparam int unsigned HOLD_CYC_DEFAULT = 2;

  localparam logic OP_SET   = 1'b1;
  localparam logic OP_RESET = 1'b0;

  typedef logic [2:0] state_t;

  localparam state_t StInit   = 3'd0;
  localparam state_t StIdle   = 3'd1;
  localparam state_t StSetup  = 3'd2;
  localparam state_t StEnable = 3'd3;
  localparam state_t StClose  = 3'd4;
  localparam state_t StAck    = 3'd5;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin selector.
// Ports:
//   req_i  - request vector
//   ptr_i  - index with first priority (search start)
//   gnt_o  - one-hot winner (all zero when no request)
//   idx_o  - binary index of the winner (0 when no request)
module rr_arbiter #(
  parameter int unsigned NumReq = 4,
  parameter int unsigned IdxW   = 2
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdxW-1:0]   ptr_i,
  output logic [NumReq-1:0] gnt_o,
  output logic [IdxW-1:0]   idx_o
);

  logic [IdxW-1:0] cand;
  logic            found;

  // Walk from ptr_i upwards with wrap; the first requester seen wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned off = 0; off < NumReq; off++) begin
      cand = IdxW'((32'(ptr_i) + off) % NumReq);
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/sr_latch_ctrl.sv
// sr_latch_ctrl: arbitrates N_REQ requesters onto one external gated SR latch.
// After reset the latch is forced to Q=0; each granted request then writes
// the latch with the requester's op, samples Q and reports the outcome.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   req, op_set         - per-requester level request and op (1=set, 0=reset)
//   grant, ack          - one-hot transaction-in-progress / completion pulse
//   err                 - pulses with ack when sampled Q differs from op
//   busy                - high in every state except IDLE
//   lat_en/lat_s/lat_r  - En, S, R drive to the external latch
//   lat_q               - Q from the external latch
module sr_latch_ctrl
  import sr_latch_pkg::*;
#(
  parameter int unsigned N_REQ    = N_REQ_DEFAULT,
  parameter int unsigned HOLD_CYC = HOLD_CYC_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] op_set,
  output logic [N_REQ-1:0] grant,
  output logic [N_REQ-1:0] ack,
  output logic             err,
  output logic             busy,
  output logic             lat_en,
  output logic             lat_s,
  output logic             lat_r,
  input  logic             lat_q
);

  localparam int unsigned IdxW = $clog2(N_REQ);

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             init_go_q, init_go_d;
  logic [IdxW-1:0]  ptr_q, ptr_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic             op_q, op_d;
  logic             smp_q, smp_d;

  logic [N_REQ-1:0] arb_gnt;
  logic [IdxW-1:0]  arb_idx;
  logic             init_drive;
  logic             write_phase;

  rr_arbiter #(
    .NumReq (N_REQ),
    .IdxW   (IdxW)
  ) u_arb (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    init_go_d = init_go_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    op_d      = op_q;
    smp_d     = smp_q;
    unique case (state_q)
      // init_go_q=0 is the idle reset phase; cnt_q counts the drive cycles
      // down to 0, and cnt_q==0 with init_go_q=1 is the quiet gap cycle.
      StInit: begin
        if (!init_go_q) begin
          init_go_d = 1'b1;
          cnt_d     = 4'(HOLD_CYC);
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          init_go_d = 1'b0;
          state_d   = StIdle;
        end
      end
      StIdle: begin
        if (|req) begin
          grant_d = arb_gnt;
          op_d    = op_set[arb_idx];
          ptr_d   = (arb_idx == IdxW'(N_REQ - 1)) ? '0 : arb_idx + 1'b1;
          state_d = StSetup;
        end
      end
      StSetup: begin
        cnt_d   = 4'(HOLD_CYC);
        state_d = StEnable;
      end
      StEnable: begin
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = StClose;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StClose: begin
        smp_d   = lat_q;
        state_d = StAck;
      end
      StAck: begin
        grant_d = '0;
        state_d = StIdle;
      end
      default: begin
        init_go_d = 1'b0;
        cnt_d     = 4'd0;
        grant_d   = '0;
        state_d   = StInit;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StInit;
      cnt_q     <= 4'd0;
      init_go_q <= 1'b0;
      ptr_q     <= '0;
      grant_q   <= '0;
      op_q      <= OP_RESET;
      smp_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      init_go_q <= init_go_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      op_q      <= op_d;
      smp_q     <= smp_d;
    end
  end

  // S and R derive from a single op bit, so both can never be high together.
  assign init_drive  = (state_q == StInit) && init_go_q && (cnt_q != 4'd0);
  assign write_phase = (state_q == StSetup) || (state_q == StEnable);

  assign lat_en = init_drive || (state_q == StEnable);
  assign lat_s  = write_phase && op_q;
  assign lat_r  = init_drive || (write_phase && !op_q);
  assign grant  = grant_q;
  assign ack    = (state_q == StAck) ? grant_q : '0;
  assign err    = (state_q == StAck) && (smp_q != op_q);
  assign busy   = (state_q != StIdle);

endmodule

// File: tb/tb_sr_latch_ctrl.sv
module tb_sr_latch_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] op_set;
  logic [3:0] grant;
  logic [3:0] ack;
  logic       err;
  logic       busy;
  logic       lat_en;
  logic       lat_s;
  logic       lat_r;
  logic       lat_q;

  logic model_q;
  logic stuck0;
  logic mon_en;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [3:0] ack;
    logic       err;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  sr_latch_ctrl #(
    .N_REQ    (4),
    .HOLD_CYC (2)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .op_set (op_set),
    .grant  (grant),
    .ack    (ack),
    .err    (err),
    .busy   (busy),
    .lat_en (lat_en),
    .lat_s  (lat_s),
    .lat_r  (lat_r),
    .lat_q  (lat_q)
  );

  // Clocked stand-in for the external gated SR latch, with a stuck-at-0 fault option.
  always @(posedge clk) begin
    if (lat_en === 1'b1) begin
      if (lat_s === 1'b1) model_q <= 1'b1;
      else if (lat_r === 1'b1) model_q <= 1'b0;
    end
  end
  assign lat_q = stuck0 ? 1'b0 : model_q;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] a, input logic e);
    exp_t x;
    x.ack = a;
    x.err = e;
    sb.push_back(x);
  endtask

  task automatic wait_en(input int budget);
    int n = 0;
    while (lat_en !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check("lat_en_seen", 32'(lat_en), 32'd1);
  endtask

  task automatic wait_sb(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  // Every-cycle checks plus scoreboard pop on ack.
  always @(negedge clk) begin
    if (mon_en) begin
      check("sr_exclusive", 32'(lat_s & lat_r), 32'd0);
      check("grant_onehot0", 32'($countones(grant) <= 1), 32'd1);
      if (ack !== 4'b0 || err !== 1'b0) begin
        check("ack_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          exp_t x;
          x = sb.pop_front();
          check("ack_vec", 32'(ack), 32'(x.ack));
          check("err_val", 32'(err), 32'(x.err));
        end
      end
    end
  end

  initial begin
    rst    = 1'b1;
    req    = 4'b0;
    op_set = 4'b0;
    stuck0 = 1'b0;
    mon_en = 1'b0;
    @(posedge clk);
    tick();
    mon_en = 1'b1;

    // Reset state
    check("rst_lat_en", 32'(lat_en), 32'd0);
    check("rst_lat_r", 32'(lat_r), 32'd0);
    check("rst_lat_s", 32'(lat_s), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_grant", 32'(grant), 32'd0);
    tick();

    // INIT: requests ignored, R+En for two cycles, then a gap cycle
    rst = 1'b0;
    req = 4'b1111;
    tick();
    check("init1_en", 32'(lat_en), 32'd1);
    check("init1_r", 32'(lat_r), 32'd1);
    check("init1_grant", 32'(grant), 32'd0);
    tick();
    check("init2_en", 32'(lat_en), 32'd1);
    check("init2_r", 32'(lat_r), 32'd1);
    req = 4'b0;
    tick();
    check("init3_en", 32'(lat_en), 32'd0);
    check("init3_r", 32'(lat_r), 32'd0);
    check("init3_busy", 32'(busy), 32'd1);
    tick();
    check("init_done_busy", 32'(busy), 32'd0);
    check("init_q", 32'(lat_q), 32'd0);

    // Single set on requester 0, cycle by cycle
    req    = 4'b0001;
    op_set = 4'b0001;
    push(4'b0001, 1'b0);
    tick();
    check("setup_grant", 32'(grant), 32'b0001);
    check("setup_s", 32'(lat_s), 32'd1);
    check("setup_r", 32'(lat_r), 32'd0);
    check("setup_en", 32'(lat_en), 32'd0);
    tick();
    check("en1", 32'(lat_en), 32'd1);
    check("en1_s", 32'(lat_s), 32'd1);
    tick();
    check("en2", 32'(lat_en), 32'd1);
    tick();
    check("close_en", 32'(lat_en), 32'd0);
    check("close_s", 32'(lat_s), 32'd0);
    tick();
    check("ack_cycle5", 32'(ack), 32'b0001);
    check("ack_err", 32'(err), 32'd0);
    req = 4'b0;
    tick();
    check("post_grant", 32'(grant), 32'd0);
    check("post_busy", 32'(busy), 32'd0);
    check("post_q", 32'(lat_q), 32'd1);
    check("sb_after_single", 32'(sb.size()), 32'd0);

    // Stuck-at-0 latch: set must report err with ack
    stuck0 = 1'b1;
    req    = 4'b0010;
    op_set = 4'b0010;
    push(4'b0010, 1'b1);
    wait_sb(20);
    req    = 4'b0;
    stuck0 = 1'b0;
    tick();

    // Reset during ENABLE: no ack, grant cleared, INIT replays
    req    = 4'b0100;
    op_set = 4'b0100;
    wait_en(20);
    rst = 1'b1;
    req = 4'b0;
    tick();
    check("abort_grant", 32'(grant), 32'd0);
    check("abort_ack", 32'(ack), 32'd0);
    check("abort_en", 32'(lat_en), 32'd0);
    check("abort_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    tick();
    check("replay_en", 32'(lat_en), 32'd1);
    check("replay_r", 32'(lat_r), 32'd1);
    tick();
    tick();
    tick();
    check("replay_idle", 32'(busy), 32'd0);
    check("replay_q", 32'(lat_q), 32'd0);

    // All four requesting with mixed ops: round robin from index 0
    op_set = 4'b0101;
    push(4'b0001, 1'b0);
    push(4'b0010, 1'b0);
    push(4'b0100, 1'b0);
    push(4'b1000, 1'b0);
    push(4'b0001, 1'b0);
    req = 4'b1111;
    wait_sb(60);
    req = 4'b0;
    tick();
    tick();
    check("rr_idle", 32'(busy), 32'd0);
    check("rr_q", 32'(lat_q), 32'd1);

    // Drop req and flip op mid-ENABLE: registered reset op still completes
    req    = 4'b1000;
    op_set = 4'b0000;
    push(4'b1000, 1'b0);
    wait_en(20);
    req    = 4'b0;
    op_set = 4'b1111;
    wait_sb(20);
    tick();
    check("flip_q", 32'(lat_q), 32'd0);
    check("flip_idle", 32'(busy), 32'd0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
